imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RV32/RV64 integer pipeline.
- Takes a 32-bit instruction word through a valid/ready handshake.
- Decodes the instruction format, then outputs the sign-extended XLEN-bit immediate, a format code and an illegal-opcode flag.
- Two register stages, full throughput, downstream backpressure and pipeline flush; sits between IF/ID and the ID-stage operand mux.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
BR_LSB0, 1, B/J immediates: 1 = byte offset (bit0 forced 0); 0 = halfword units (legacy, no appended 0).
ERR_CNT_W, 8, width of the saturating illegal-opcode counter (feature only).

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous reset, active-low
flush_i  in  1  discard all in-flight and presented instructions
valid_i  in  1  instr_i valid
ready_o  out  1  block can accept instr_i
instr_i  in  32  instruction word
valid_o  out  1  imm_o/fmt_o/err_o valid
ready_i  in  1  consumer accepts output
imm_o  out  XLEN  sign-extended immediate
fmt_o  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
err_o  out  1  opcode not recognised
err_cnt_o  out  ERR_CNT_W  illegal-opcode count (feature only)

Behaviour:
- Reset (rst_n_i low, async): both stage valids 0; valid_o=0, imm_o=0, fmt_o=0, err_o=0, err_cnt_o=0.
- Transfers: input when valid_i&ready_o; output when valid_o&ready_i.
- Stage 1 (S1) registers instr_i and the decoded format.
- Stage 2 (S2) assembles and sign-extends the immediate (sign bit = instr[31] for every format) and drives outputs from registers.
- Latency: 2 cycles, accept edge to valid_o, with no stall. Throughput: 1 per cycle.
- Advance rules:
  - S2 loads when !S2.valid | ready_i.
  - S1 advances when S2 loads.
  - ready_o = !S1.valid | S1 advance.
  - No combinational path from valid_i to valid_o. Only ready_i reaches ready_o combinationally.
- Stall: when valid_o=1 and ready_i=0, S2 outputs are held stable and S1 holds; after one more accepted instruction, ready_o=0. No loss, no duplication, order preserved.
- Decode (opcode instr[6:0]):
  - I: 0010011, 0000011, 1100111; plus 0011011 when XLEN=64. Immediate = instr[31:20].
  - S: 0100011. Immediate = {instr[31:25], instr[11:7]}.
  - B: 1100011. Immediate = {instr[31], instr[7], instr[30:25], instr[11:8]}, with a 0 appended iff BR_LSB0.
  - U: 0110111, 0010111. Immediate = {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J: 1101111. Immediate = {instr[31], instr[19:12], instr[20], instr[30:21]}, with a 0 appended iff BR_LSB0.
  - R: 0110011; plus 0111011 when XLEN=64. imm_o=0, err_o=0.
  - Other: fmt_o=7, err_o=1, imm_o=0. The instruction still flows; no simulation messages.
- Flush:
  - flush_i=1 at an edge clears S1.valid and S2.valid.
  - An instruction presented in the same cycle is dropped; ready_o is still 1 during flush.
  - Data registers are don't-care after flush; valid_o=0 on the next cycle.
  - Flush overrides stall.
- Reset mid-operation: in-flight items are lost; after release, behaviour is identical to a fresh start.

Optional Feature:
IMM_GEN_ERRCNT_EN
- Defined: err_cnt_o increments by 1 on each output transfer with err_o=1 and saturates at all-ones. Reset to 0; flushed illegal instructions are not counted.
- Undefined: the counter logic is absent and err_cnt_o is tied to 0.

Test Plan:
1. XLEN=32. Send 0xFFF00093 (addi -1), ready_i=1 -> 2 cycles later valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1, err_o=0.
2. Send 0xFE112E23 (sw x1,-4(x2)) -> imm_o=0xFFFFFFFC, fmt_o=2. Then 0xFE000CE3 (beq -8) -> BR_LSB0=1: 0xFFFFFFF8; BR_LSB0=0: 0xFFFFFFFC; fmt_o=3.
3. XLEN=64. Send 0x123452B7 -> imm_o=0x0000000012345000, fmt_o=4. Then 0xFFFFF2B7 -> 0xFFFFFFFFFFFFF000.
4. Back-to-back A, B, C with ready_i=0 for 4 cycles -> ready_o drops after B; imm_o holds A. On ready_i=1, outputs A, B, C in order with no gaps.
5. Send 0x0000007F -> fmt_o=7, err_o=1, imm_o=0. With IMM_GEN_ERRCNT_EN, err_cnt_o goes 0->1. Force 300 illegal instructions -> saturates at 255.
6. Two instructions in flight plus a third presented, flush_i pulsed 1 cycle -> valid_o=0 next cycle, none of the three emitted. Assert rst_n_i mid-stream -> outputs go to reset values immediately.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 flush_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [31:0]          instr_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [XLEN-1:0]      imm_o;
  logic [2:0]           fmt_o;
  logic                 err_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;

  modport slave (
    input  flush_i, valid_i, instr_i, ready_i,
    output ready_o, valid_o, imm_o, fmt_o, err_o, err_cnt_o
  );

  modport master (
    output flush_i, valid_i, instr_i, ready_i,
    input  ready_o, valid_o, imm_o, fmt_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - two-stage RV32/RV64 immediate generator; IMM_GEN_ERRCNT_EN adds an illegal-opcode counter
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int BR_LSB0   = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Opcode bits are consumed by the S1 decoder, so S1 keeps only [31:7].
  logic               s1_valid;
  logic [31:7]        s1_ins;
  logic [2:0]         s1_fmt;
  logic               s2_valid;
  logic [XLEN-1:0]    s2_imm;
  logic [2:0]         s2_fmt;
  logic               s2_err;

  logic [2:0]         dec_fmt;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_ext;
  logic               s2_load;
  logic               in_ready;

  // S2 refills when empty or draining; S1 can only move into a loading S2.
  assign s2_load  = !s2_valid || bus.ready_i;
  assign in_ready = !s1_valid || s2_load;

  // Classify the incoming opcode; the W-variants only exist on RV64.
  always_comb begin
    dec_fmt = FMT_ILL;
    case (bus.instr_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FMT_I;
      7'b0011011:                         dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0100011:                         dec_fmt = FMT_S;
      7'b1100011:                         dec_fmt = FMT_B;
      7'b0110111, 7'b0010111:             dec_fmt = FMT_U;
      7'b1101111:                         dec_fmt = FMT_J;
      7'b0110011:                         dec_fmt = FMT_R;
      7'b0111011:                         dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                            dec_fmt = FMT_ILL;
    endcase
  end

  // Scatter the immediate fields into a 32-bit signed value, then widen to XLEN.
  always_comb begin
    imm32 = '0;
    case (s1_fmt)
      FMT_I: imm32 = {{20{s1_ins[31]}}, s1_ins[31:20]};
      FMT_S: imm32 = {{20{s1_ins[31]}}, s1_ins[31:25], s1_ins[11:7]};
      FMT_B: imm32 = (BR_LSB0 != 0)
                   ? {{19{s1_ins[31]}}, s1_ins[31], s1_ins[7], s1_ins[30:25], s1_ins[11:8], 1'b0}
                   : {{20{s1_ins[31]}}, s1_ins[31], s1_ins[7], s1_ins[30:25], s1_ins[11:8]};
      FMT_U: imm32 = {s1_ins[31:12], 12'b0};
      FMT_J: imm32 = (BR_LSB0 != 0)
                   ? {{11{s1_ins[31]}}, s1_ins[31], s1_ins[19:12], s1_ins[20], s1_ins[30:21], 1'b0}
                   : {{12{s1_ins[31]}}, s1_ins[31], s1_ins[19:12], s1_ins[20], s1_ins[30:21]};
      default: imm32 = '0;
    endcase
    imm_ext = XLEN'(imm32);
  end

  // S1: capture the instruction and its decoded format; flush drops whatever is held or presented.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_ins   <= '0;
      s1_fmt   <= FMT_R;
    end else if (bus.flush_i) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1_ins <= bus.instr_i[31:7];
        s1_fmt <= dec_fmt;
      end
    end
  end

  // S2: register the assembled immediate; contents hold while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid <= 1'b0;
      s2_imm   <= '0;
      s2_fmt   <= FMT_R;
      s2_err   <= 1'b0;
    end else if (bus.flush_i) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_imm <= imm_ext;
        s2_fmt <= s1_fmt;
        s2_err <= (s1_fmt == FMT_ILL);
      end
    end
  end

  assign bus.ready_o = in_ready;
  assign bus.valid_o = s2_valid;
  assign bus.imm_o   = s2_imm;
  assign bus.fmt_o   = s2_fmt;
  assign bus.err_o   = s2_err;

`ifdef IMM_GEN_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  // Count illegal opcodes as they leave the block, sticking at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt <= '0;
    end else if (s2_valid && bus.ready_i && s2_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.err_cnt_o = err_cnt;
`else
  assign bus.err_cnt_o = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (RV32, RV64, halfword-offset builds)
module tb_imm_gen_pipe;
  logic clk_i;
  logic rst_n_i;
  int   checks;
  int   errors;

  imm_gen_pipe_if #(.XLEN(32), .ERR_CNT_W(8)) bus   ();
  imm_gen_pipe_if #(.XLEN(64), .ERR_CNT_W(8)) bus64 ();
  imm_gen_pipe_if #(.XLEN(32), .ERR_CNT_W(8)) bush  ();

  assign bus64.flush_i = bus.flush_i;
  assign bus64.valid_i = bus.valid_i;
  assign bus64.instr_i = bus.instr_i;
  assign bus64.ready_i = bus.ready_i;
  assign bush.flush_i  = bus.flush_i;
  assign bush.valid_i  = bus.valid_i;
  assign bush.instr_i  = bus.instr_i;
  assign bush.ready_i  = bus.ready_i;

  imm_gen_pipe #(.XLEN(32), .BR_LSB0(1), .ERR_CNT_W(8)) u_dut   (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));
  imm_gen_pipe #(.XLEN(64), .BR_LSB0(1), .ERR_CNT_W(8)) u_dut64 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus64));
  imm_gen_pipe #(.XLEN(32), .BR_LSB0(0), .ERR_CNT_W(8)) u_duth  (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bush));

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    bus.instr_i = ins;
    bus.valid_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n_i     = 1'b0;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.instr_i = '0;
    bus.ready_i = 1'b1;
    step();
    step();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", bus.valid_o); end
    checks++; if ({bus.imm_o, bus.fmt_o, bus.err_o} !== {32'h0, 3'd0, 1'b0}) begin errors++; $display("FAIL rst_data: got %h/%0d/%b exp 0/0/0", bus.imm_o, bus.fmt_o, bus.err_o); end
    checks++; if (bus.err_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", bus.err_cnt_o); end
    checks++; if (bus64.imm_o !== 64'h0) begin errors++; $display("FAIL rst_imm64: got %h exp 0", bus64.imm_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", bus.ready_o); end
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_i_type();
    bus.instr_i = 32'hFFF00093;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL lat_early: got valid %b exp 0", bus.valid_o); end
    step();
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL lat_valid: got valid %b exp 1", bus.valid_o); end
    checks++; if ({bus.imm_o, bus.fmt_o, bus.err_o} !== {32'hFFFFFFFF, 3'd1, 1'b0}) begin errors++; $display("FAIL addi32: got %h/%0d/%b exp ffffffff/1/0", bus.imm_o, bus.fmt_o, bus.err_o); end
    checks++; if ({bus64.imm_o, bus64.fmt_o} !== {64'hFFFFFFFFFFFFFFFF, 3'd1}) begin errors++; $display("FAIL addi64: got %h/%0d exp ffffffffffffffff/1", bus64.imm_o, bus64.fmt_o); end
    step();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL addi_once: got valid %b exp 0", bus.valid_o); end
  endtask

  task automatic test_s_b();
    bit ok;
    send(32'hFE112E23);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sw_timeout: got no valid_o exp valid_o"); end
    checks++; if ({bus.imm_o, bus.fmt_o, bus.err_o} !== {32'hFFFFFFFC, 3'd2, 1'b0}) begin errors++; $display("FAIL sw: got %h/%0d/%b exp fffffffc/2/0", bus.imm_o, bus.fmt_o, bus.err_o); end
    send(32'hFE000CE3);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL beq_timeout: got no valid_o exp valid_o"); end
    checks++; if ({bus.imm_o, bus.fmt_o} !== {32'hFFFFFFF8, 3'd3}) begin errors++; $display("FAIL beq_lsb0: got %h/%0d exp fffffff8/3", bus.imm_o, bus.fmt_o); end
    checks++; if ({bush.imm_o, bush.fmt_o} !== {32'hFFFFFFFC, 3'd3}) begin errors++; $display("FAIL beq_half: got %h/%0d exp fffffffc/3", bush.imm_o, bush.fmt_o); end
    step();
  endtask

  task automatic test_u_xlen64();
    bit ok;
    send(32'h123452B7);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lui_timeout: got no valid_o exp valid_o"); end
    checks++; if ({bus64.imm_o, bus64.fmt_o} !== {64'h0000000012345000, 3'd4}) begin errors++; $display("FAIL lui64_pos: got %h/%0d exp 0000000012345000/4", bus64.imm_o, bus64.fmt_o); end
    checks++; if (bus.imm_o !== 32'h12345000) begin errors++; $display("FAIL lui32_pos: got %h exp 12345000", bus.imm_o); end
    send(32'hFFFFF2B7);
    wait_out(ok);
    checks++; if ({bus64.imm_o, bus64.fmt_o} !== {64'hFFFFFFFFFFFFF000, 3'd4}) begin errors++; $display("FAIL lui64_neg: got %h/%0d exp fffffffffffff000/4", bus64.imm_o, bus64.fmt_o); end
    step();
  endtask

  task automatic test_j_r();
    bit ok;
    send(32'hFFDFF06F);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL jal_timeout: got no valid_o exp valid_o"); end
    checks++; if ({bus.imm_o, bus.fmt_o} !== {32'hFFFFFFFC, 3'd5}) begin errors++; $display("FAIL jal_lsb0: got %h/%0d exp fffffffc/5", bus.imm_o, bus.fmt_o); end
    checks++; if ({bush.imm_o, bush.fmt_o} !== {32'hFFFFFFFE, 3'd5}) begin errors++; $display("FAIL jal_half: got %h/%0d exp fffffffe/5", bush.imm_o, bush.fmt_o); end
    send(32'h002081B3);
    wait_out(ok);
    checks++; if ({bus.imm_o, bus.fmt_o, bus.err_o} !== {32'h0, 3'd0, 1'b0}) begin errors++; $display("FAIL add_r: got %h/%0d/%b exp 0/0/0", bus.imm_o, bus.fmt_o, bus.err_o); end
    send(32'hFFF0009B);
    wait_out(ok);
    checks++; if ({bus64.imm_o, bus64.fmt_o, bus64.err_o} !== {64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}) begin errors++; $display("FAIL addiw64: got %h/%0d/%b exp ffffffffffffffff/1/0", bus64.imm_o, bus64.fmt_o, bus64.err_o); end
    checks++; if ({bus.imm_o, bus.fmt_o, bus.err_o} !== {32'h0, 3'd7, 1'b1}) begin errors++; $display("FAIL addiw32: got %h/%0d/%b exp 0/7/1", bus.imm_o, bus.fmt_o, bus.err_o); end
    send(32'h0000003B);
    wait_out(ok);
    checks++; if ({bus64.fmt_o, bus64.err_o, bus.fmt_o, bus.err_o} !== {3'd0, 1'b0, 3'd7, 1'b1}) begin errors++; $display("FAIL addw: got 64:%0d/%b 32:%0d/%b exp 64:0/0 32:7/1", bus64.fmt_o, bus64.err_o, bus.fmt_o, bus.err_o); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.ready_i = 1'b0;
    bus.instr_i = 32'hFFF00093;
    bus.valid_i = 1'b1;
    step();
    bus.instr_i = 32'h00100093;
    step();
    checks++; if ({bus.valid_o, bus.imm_o, bus.ready_o} !== {1'b1, 32'hFFFFFFFF, 1'b0}) begin errors++; $display("FAIL b2b_fill: got v%b %h r%b exp v1 ffffffff r0", bus.valid_o, bus.imm_o, bus.ready_o); end
    bus.instr_i = 32'h123452B7;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if ({bus.valid_o, bus.imm_o, bus.ready_o} !== {1'b1, 32'hFFFFFFFF, 1'b0}) begin errors++; $display("FAIL b2b_hold%0d: got v%b %h r%b exp v1 ffffffff r0", c, bus.valid_o, bus.imm_o, bus.ready_o); end
    end
    bus.ready_i = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", bus.ready_o); end
    step();
    bus.valid_i = 1'b0;
    checks++; if ({bus.valid_o, bus.imm_o} !== {1'b1, 32'h00000001}) begin errors++; $display("FAIL b2b_B: got v%b %h exp v1 00000001", bus.valid_o, bus.imm_o); end
    step();
    checks++; if ({bus.valid_o, bus.imm_o, bus.fmt_o} !== {1'b1, 32'h12345000, 3'd4}) begin errors++; $display("FAIL b2b_C: got v%b %h/%0d exp v1 12345000/4", bus.valid_o, bus.imm_o, bus.fmt_o); end
    step();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid %b exp 0", bus.valid_o); end
  endtask

  task automatic test_illegal();
    bit ok;
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    send(32'h0000007F);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ill_timeout: got no valid_o exp valid_o"); end
    checks++; if ({bus.imm_o, bus.fmt_o, bus.err_o} !== {32'h0, 3'd7, 1'b1}) begin errors++; $display("FAIL ill: got %h/%0d/%b exp 0/7/1", bus.imm_o, bus.fmt_o, bus.err_o); end
`ifdef IMM_GEN_ERRCNT_EN
    checks++; if (bus.err_cnt_o !== 8'd0) begin errors++; $display("FAIL cnt_before: got %0d exp 0", bus.err_cnt_o); end
    step();
    checks++; if (bus.err_cnt_o !== 8'd1) begin errors++; $display("FAIL cnt_one: got %0d exp 1", bus.err_cnt_o); end
`else
    step();
    checks++; if (bus.err_cnt_o !== 8'd0) begin errors++; $display("FAIL cnt_tied: got %0d exp 0", bus.err_cnt_o); end
`endif
    bus.instr_i = 32'h0000007F;
    bus.valid_i = 1'b1;
    repeat (300) step();
    bus.valid_i = 1'b0;
    repeat (4) step();
`ifdef IMM_GEN_ERRCNT_EN
    checks++; if (bus.err_cnt_o !== 8'd255) begin errors++; $display("FAIL cnt_sat: got %0d exp 255", bus.err_cnt_o); end
`else
    checks++; if (bus.err_cnt_o !== 8'd0) begin errors++; $display("FAIL cnt_tied_sat: got %0d exp 0", bus.err_cnt_o); end
`endif
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    bus.ready_i = 1'b0;
    bus.instr_i = 32'h00100093;
    bus.valid_i = 1'b1;
    step();
    bus.instr_i = 32'h00200093;
    step();
    bus.instr_i = 32'h00300093;
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got valid %b exp 0", bus.valid_o); end
    bus.ready_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.valid_o !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_leak: got valid_o after flush exp none"); end
    send(32'h00400093);
    bus.instr_i = 32'h00500093;
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", bus.ready_o); end
    step();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.valid_o !== 1'b0) seen = 1'b1;
      step();
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_drop: got valid_o after flush exp none"); end
    send(32'h00600093);
    wait_out(ok);
    checks++; if ({ok, bus.imm_o} !== {1'b1, 32'h00000006}) begin errors++; $display("FAIL flush_recover: got ok%b %h exp ok1 00000006", ok, bus.imm_o); end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.ready_i = 1'b1;
    bus.instr_i = 32'hFFF00093;
    bus.valid_i = 1'b1;
    step();
    step();
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++; if ({bus.valid_o, bus.imm_o, bus.fmt_o, bus.err_o} !== {1'b0, 32'h0, 3'd0, 1'b0}) begin errors++; $display("FAIL rst_mid: got v%b %h/%0d/%b exp v0 0/0/0", bus.valid_o, bus.imm_o, bus.fmt_o, bus.err_o); end
    bus.valid_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_empty: got valid %b exp 0", bus.valid_o); end
    send(32'hFE112E23);
    wait_out(ok);
    checks++; if ({ok, bus.imm_o, bus.fmt_o} !== {1'b1, 32'hFFFFFFFC, 3'd2}) begin errors++; $display("FAIL rst_mid_after: got ok%b %h/%0d exp ok1 fffffffc/2", ok, bus.imm_o, bus.fmt_o); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_i_type();
    test_s_b();
    test_u_xlen64();
    test_j_r();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
